// File: rtl/fractal_pkg.sv
// Shared widths and per-slot bookkeeping types for the fractal pixel dispatcher.
package fractal_pkg;

  localparam int NUM_ENGINES_DEF = 4;
  localparam int ITER_WIDTH_DEF  = 6;
  localparam int PIX_WIDTH_DEF   = 10;

  // One slot per engine: in flight, result waiting, or in flight but abandoned by a flush.
  typedef struct packed {
    logic pending;
    logic filled;
    logic discard;
  } slot_flags_t;

endpackage

// File: rtl/fractal_wrap_counter.sv
// Modulo-MAX counter (0..MAX-1) with synchronous clear; clear wins over increment.
module fractal_wrap_counter #(
  parameter  int MAX = 4,
  localparam int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= (cnt == W'(MAX - 1)) ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/fractal_pixel_dispatcher.sv
// Round-robin pixel issue to mandelbrot engines with in-order result retirement.
module fractal_pixel_dispatcher
  import fractal_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int ITER_WIDTH  = ITER_WIDTH_DEF,
  parameter int PIX_WIDTH   = PIX_WIDTH_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic [PIX_WIDTH-1:0]              pix_x,
  input  logic [PIX_WIDTH-1:0]              pix_y,
  input  logic                              flush,
  input  logic [ITER_WIDTH-1:0]             max_iter_limit,
  output logic [NUM_ENGINES-1:0]            eng_start,
  output logic [PIX_WIDTH-1:0]              eng_x,
  output logic [PIX_WIDTH-1:0]              eng_y,
  input  logic [NUM_ENGINES-1:0]            eng_done,
  input  logic [NUM_ENGINES*ITER_WIDTH-1:0] eng_iter,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ITER_WIDTH-1:0]             out_iter,
  output logic                              out_in_set
);

  localparam int PTR_W = $clog2(NUM_ENGINES);

  slot_flags_t [NUM_ENGINES-1:0]                 slot;
  logic        [NUM_ENGINES-1:0][ITER_WIDTH-1:0] result;
  logic        [PTR_W-1:0]                       wr_ptr, rd_ptr;
  logic                                          fire, load;

  assign pix_ready = !rst && !flush && !slot[wr_ptr].pending && !slot[wr_ptr].filled;
  assign fire      = pix_valid && pix_ready;
  assign load      = !flush && slot[rd_ptr].filled && (!out_valid || out_ready);
  assign eng_start = fire ? (NUM_ENGINES'(1) << wr_ptr) : '0;
  assign eng_x     = pix_x;
  assign eng_y     = pix_y;

  fractal_wrap_counter #(.MAX(NUM_ENGINES)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (fire),
    .clr (flush),
    .cnt (wr_ptr)
  );

  fractal_wrap_counter #(.MAX(NUM_ENGINES)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (load),
    .clr (flush),
    .cnt (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot   <= '0;
      result <= '0;
    end else begin
      for (int k = 0; k < NUM_ENGINES; k++) begin
        if (flush) begin
          // An engine finishing on the flush edge is already idle, so it needs no discard.
          slot[k].pending <= slot[k].pending && !eng_done[k];
          slot[k].discard <= slot[k].pending && !eng_done[k];
          slot[k].filled  <= 1'b0;
        end else begin
          if (eng_done[k] && slot[k].pending) begin
            slot[k].pending <= 1'b0;
            slot[k].discard <= 1'b0;
            if (!slot[k].discard) begin
              slot[k].filled <= 1'b1;
              result[k]      <= eng_iter[k*ITER_WIDTH +: ITER_WIDTH];
            end
          end else if (fire && wr_ptr == PTR_W'(k)) begin
            slot[k].pending <= 1'b1;
          end
          if (load && rd_ptr == PTR_W'(k))
            slot[k].filled <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_iter   <= '0;
      out_in_set <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_iter   <= result[rd_ptr];
      out_in_set <= result[rd_ptr] >= max_iter_limit;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
